// File: rtl/nand_three_seq.sv
// Self-checking stimulus sequencer for one nand_three gate: steps {A,B,C} through all
// eight vectors, samples Y after DWELL cycles, counts mismatches. Option: NAND_THREE_SEQ_GRAY_EN.
module nand_three_seq #(
  parameter int DWELL = 4,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             A,
  output logic             B,
  output logic             C,
  input  logic             Y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       fail_vec
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int              CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [1:0]       r_state;
  logic [2:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_abc;
  logic [ERR_W-1:0] r_err;
  logic [2:0]       r_fail;
  logic             r_ff;

  logic w_mismatch;

  // Vector index to applied {A,B,C}; the Gray build toggles exactly one input per step.
  function automatic logic [2:0] order(input logic [2:0] i);
`ifdef NAND_THREE_SEQ_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  assign w_mismatch = (Y != ~(&r_abc));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= 3'd0;
      r_cnt   <= '0;
      r_abc   <= 3'b000;
      r_err   <= '0;
      r_fail  <= 3'b000;
      r_ff    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_SETTLE;
            r_idx   <= 3'd0;
            r_cnt   <= '0;
            r_abc   <= order(3'd0);
            r_err   <= '0;
            r_fail  <= 3'b000;
            r_ff    <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (r_cnt == CNT_LAST) r_state <= S_CHECK;
          else                   r_cnt   <= r_cnt + CNT_W'(1);
        end
        S_CHECK: begin
          if (w_mismatch) begin
            r_err <= sat_inc(r_err);
            if (!r_ff) begin
              r_fail <= r_abc;
              r_ff   <= 1'b1;
            end
          end
          if (r_idx == 3'd7) begin
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + 3'd1;
            r_abc   <= order(r_idx + 3'd1);
            r_cnt   <= '0;
            r_state <= S_SETTLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign A        = r_abc[2];
  assign B        = r_abc[1];
  assign C        = r_abc[0];
  assign busy     = (r_state == S_SETTLE) || (r_state == S_CHECK);
  assign done     = (r_state == S_DONE);
  assign pass     = done && (r_err == '0);
  assign err_cnt  = r_err;
  assign fail_vec = r_fail;

endmodule

// File: tb/tb_nand_three_seq.sv
// Directed bench for nand_three_seq: a wide (ERR_W=4) and a narrow (ERR_W=2) instance
// run side by side against a behavioural gate with selectable stuck-at faults.
module tb_nand_three_seq;

  localparam int DWELL = 4;
  localparam int VCYC  = DWELL + 1;
  localparam int RUNC  = 8 * VCYC;

  logic clk = 1'b0;
  logic rst, start;
  logic a0, b0, c0, y0, busy0, done0, pass0;
  logic [3:0] err0;
  logic [2:0] fv0;
  logic a1, b1, c1, y1, busy1, done1, pass1;
  logic [1:0] err1;
  logic [2:0] fv1;
  int ymode;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         ymode;
    bit         repulse;
    logic [3:0] err;
    logic [1:0] err2;
    logic [2:0] fvec;
    bit         pass;
  } vec_t;

  vec_t       tbl[4];
  logic [2:0] ord[8];

  always #5 clk = ~clk;

  // 0: healthy NAND, 1: Y stuck-at-1, 2: Y stuck-at-0
  always_comb begin
    y0 = (ymode == 0) ? ~(a0 & b0 & c0) : (ymode == 1);
    y1 = (ymode == 0) ? ~(a1 & b1 & c1) : (ymode == 1);
  end

  nand_three_seq #(.DWELL(DWELL), .ERR_W(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .A(a0), .B(b0), .C(c0), .Y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_vec(fv0)
  );

  nand_three_seq #(.DWELL(DWELL), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .A(a1), .B(b1), .C(c1), .Y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fv1)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " abc"},  {a0, b0, c0}, 0);
    chk({tag, " busy"}, busy0, 0);
    chk({tag, " done"}, done0, 0);
    chk({tag, " pass"}, pass0, 0);
    chk({tag, " err"},  err0, 0);
    chk({tag, " fvec"}, fv0, 0);
    chk({tag, " busy2"}, busy1, 0);
    chk({tag, " err2"},  err1, 0);
  endtask

  task automatic do_run(input int k);
    vec_t v;
    int   seq_bad;
    int   tim_bad;
    v = tbl[k];
    ymode = v.ymode;
    seq_bad = 0;
    tim_bad = 0;
    @(negedge clk);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk($sformatf("run%0d start busy", k), busy0, 1);
    chk($sformatf("run%0d start done", k), done0, 0);
    chk($sformatf("run%0d start err", k), err0, 0);
    chk($sformatf("run%0d start fvec", k), fv0, 0);
    chk($sformatf("run%0d start abc", k), {a0, b0, c0}, ord[0]);
    for (int e = 1; e <= RUNC; e++) begin
      tick();
      if (e < RUNC && (!busy0 || done0 || !busy1)) tim_bad++;
      if (e < RUNC && (e % VCYC) == 0 && {a0, b0, c0} != ord[e / VCYC]) seq_bad++;
      if (v.repulse && e == 12) start = 1'b1;
      if (v.repulse && e == 13) start = 1'b0;
      if (e == RUNC - 1) chk($sformatf("run%0d done early", k), done0, 0);
    end
    chk($sformatf("run%0d busy window", k), tim_bad, 0);
    chk($sformatf("run%0d vector order", k), seq_bad, 0);
    chk($sformatf("run%0d done", k), done0, 1);
    chk($sformatf("run%0d busy end", k), busy0, 0);
    chk($sformatf("run%0d err", k), err0, v.err);
    chk($sformatf("run%0d err sat", k), err1, v.err2);
    chk($sformatf("run%0d fvec", k), fv0, v.fvec);
    chk($sformatf("run%0d pass", k), pass0, v.pass);
    chk($sformatf("run%0d last abc", k), {a0, b0, c0}, ord[7]);
    tick();
    chk($sformatf("run%0d done held", k), done0, 1);
    chk($sformatf("run%0d err held", k), err0, v.err);
  endtask

  initial begin
`ifdef NAND_THREE_SEQ_GRAY_EN
    ord[0] = 3'b000; ord[1] = 3'b001; ord[2] = 3'b011; ord[3] = 3'b010;
    ord[4] = 3'b110; ord[5] = 3'b111; ord[6] = 3'b101; ord[7] = 3'b100;
`else
    ord[0] = 3'b000; ord[1] = 3'b001; ord[2] = 3'b010; ord[3] = 3'b011;
    ord[4] = 3'b100; ord[5] = 3'b101; ord[6] = 3'b110; ord[7] = 3'b111;
`endif
    tbl[0] = '{0, 1'b0, 4'd0, 2'd0, 3'b000, 1'b1};
    tbl[1] = '{1, 1'b0, 4'd1, 2'd1, 3'b111, 1'b0};
    tbl[2] = '{2, 1'b0, 4'd7, 2'd3, 3'b000, 1'b0};
    tbl[3] = '{0, 1'b1, 4'd0, 2'd0, 3'b000, 1'b1};

    ymode = 0;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    chk_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle stays idle", busy0, 0);

    for (int k = 0; k < 4; k++) do_run(k);

    // Reset in the middle of vector 3 after errors have accumulated
    ymode = 2;
    @(negedge clk);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 3 * VCYC + 1; e++) tick();
    chk("mid abc", {a0, b0, c0}, ord[3]);
    chk("mid err", err0, 3);
    chk("mid busy", busy0, 1);
    rst = 1'b1;
    tick();
    chk_reset_state("midrst");
    rst = 1'b0;
    tick();
    chk("post rst idle", busy0, 0);
    do_run(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
